// File: rtl/hv_flt_pkg.sv
// Shared types and helpers for the HV fault supervisor.
// BIST state encoding, default sizes and channel scan helper.
package hv_flt_pkg;

    localparam int CH_NUM_DEF = 6;
    localparam int DEB_W_DEF  = 4;
    localparam int TMO_W_DEF  = 8;

    typedef enum logic [2:0] {
        IDLE,
        INJ,
        REL,
        NEXT,
        DONE
    } bist_st_e;

    // Returns 16 when no bit at or above 'from' is set.
    function automatic logic [4:0] lsb_from(
        input logic [15:0] v,
        input logic [4:0]  from
    );
        logic [4:0] r;
        r = 5'd16;
        for (int i = 15; i >= 0; i--) begin
            if (v[i] && (5'(i) >= from)) begin
                r = 5'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/hv_flt_deb.sv
// Single fault channel: input synchroniser and symmetric debounce.
// o_deb follows the sampled level once it has differed for thr+1 cycles.
module hv_flt_deb
    import hv_flt_pkg::*;
#(
    parameter int DEB_W = DEB_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_raw,
    input  logic [DEB_W-1:0] i_thr,
    output logic             o_deb
);

    logic             meta;
    logic [DEB_W-1:0] cnt;

    // meta is the first sync stage; cnt/o_deb registers form the second.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            meta  <= 1'b0;
            cnt   <= '0;
            o_deb <= 1'b0;
        end else begin
            meta <= i_raw;
            if (meta == o_deb) begin
                cnt <= '0;
            end else if (cnt == i_thr) begin
                cnt   <= '0;
                o_deb <= ~o_deb;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/hv_flt_bist_ctrl.sv
// HV-die fault supervisor: debounce, sticky status, interrupt and
// a BIST sequencer that injects each enabled channel in turn.
module hv_flt_bist_ctrl
    import hv_flt_pkg::*;
#(
    parameter int CH_NUM = CH_NUM_DEF,
    parameter int DEB_W  = DEB_W_DEF,
    parameter int TMO_W  = TMO_W_DEF
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [CH_NUM-1:0]       i_flt_raw,
    input  logic [CH_NUM*DEB_W-1:0] i_reg_deb_thr,
    input  logic [CH_NUM-1:0]       i_reg_flt_mask,
    input  logic [CH_NUM-1:0]       i_reg_flt_clr,
    input  logic                    i_bist_start,
    input  logic                    i_bist_abort,
    input  logic [CH_NUM-1:0]       i_reg_bist_en,
    input  logic [TMO_W-1:0]        i_reg_bist_tmo,
    output logic [CH_NUM-1:0]       o_flt_deb,
    output logic [CH_NUM-1:0]       o_flt_sts,
    output logic                    o_flt_any,
    output logic [CH_NUM-1:0]       o_bist_inj,
    output logic                    o_bist_busy,
    output logic                    o_bist_done,
    output logic [CH_NUM-1:0]       o_bist_pass
);

    function automatic logic [CH_NUM-1:0] oh(input logic [4:0] idx);
        logic [CH_NUM-1:0] r;
        r = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (5'(i) == idx) begin
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    bist_st_e          st, st_n;
    logic [4:0]        ch, ch_n;
    logic [4:0]        first_ch, nxt_ch;
    logic [CH_NUM-1:0] en_q, en_n;
    logic [CH_NUM-1:0] pass_n, sel, test_msk;
    logic [TMO_W-1:0]  tmr, tmr_n;
    logic [15:0]       en16, start16;
    logic              deb_ch;

    for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
        hv_flt_deb #(
            .DEB_W(DEB_W)
        ) u_deb (
            .i_clk(i_clk),
            .i_rst(i_rst),
            .i_raw(i_flt_raw[k]),
            .i_thr(i_reg_deb_thr[k*DEB_W +: DEB_W]),
            .o_deb(o_flt_deb[k])
        );
    end

    always_comb begin
        en16                 = '0;
        en16[CH_NUM-1:0]     = en_q;
        start16              = '0;
        start16[CH_NUM-1:0]  = i_reg_bist_en;
    end

    assign first_ch    = lsb_from(start16, 5'd0);
    assign nxt_ch      = lsb_from(en16, ch + 5'd1);
    assign sel         = oh(ch);
    assign deb_ch      = |(o_flt_deb & sel);
    assign test_msk    = (st == INJ || st == REL) ? sel : '0;
    assign o_bist_busy = (st != IDLE);
    assign o_bist_done = (st == DONE);

    always_comb begin
        st_n   = st;
        ch_n   = ch;
        en_n   = en_q;
        tmr_n  = tmr;
        pass_n = o_bist_pass;
        unique case (st)
            IDLE: begin
                if (i_bist_start) begin
                    pass_n = '0;
                    if (|i_reg_bist_en) begin
                        en_n  = i_reg_bist_en;
                        ch_n  = first_ch;
                        tmr_n = '0;
                        st_n  = INJ;
                    end else begin
                        st_n = DONE;
                    end
                end
            end
            INJ: begin
                if (deb_ch) begin
                    pass_n = o_bist_pass | sel;
                    tmr_n  = '0;
                    st_n   = REL;
                end else if (tmr == i_reg_bist_tmo) begin
                    tmr_n = '0;
                    st_n  = REL;
                end else begin
                    tmr_n = tmr + 1'b1;
                end
            end
            REL: begin
                if (!deb_ch) begin
                    st_n = NEXT;
                end else if (tmr == i_reg_bist_tmo) begin
                    pass_n = o_bist_pass & ~sel;
                    st_n   = NEXT;
                end else begin
                    tmr_n = tmr + 1'b1;
                end
            end
            NEXT: begin
                if (nxt_ch == 5'd16) begin
                    st_n = DONE;
                end else begin
                    ch_n  = nxt_ch;
                    tmr_n = '0;
                    st_n  = INJ;
                end
            end
            DONE: st_n = IDLE;
            default: st_n = IDLE;
        endcase
        // Abort beats any same-cycle start; results kept only when idle.
        if (i_bist_abort) begin
            st_n  = IDLE;
            ch_n  = ch;
            en_n  = en_q;
            tmr_n = tmr;
            if (st != IDLE) begin
                pass_n = '0;
            end else begin
                pass_n = o_bist_pass;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            st          <= IDLE;
            ch          <= '0;
            en_q        <= '0;
            tmr         <= '0;
            o_bist_pass <= '0;
            o_bist_inj  <= '0;
            o_flt_sts   <= '0;
            o_flt_any   <= 1'b0;
        end else begin
            st          <= st_n;
            ch          <= ch_n;
            en_q        <= en_n;
            tmr         <= tmr_n;
            o_bist_pass <= pass_n;
            o_bist_inj  <= (st_n == INJ) ? oh(ch_n) : '0;
            o_flt_sts   <= (o_flt_deb & ~i_reg_flt_mask & ~test_msk)
                         | (o_flt_sts & ~i_reg_flt_clr);
            o_flt_any   <= |o_flt_sts;
        end
    end

endmodule
